// File: rtl/step_pulse_gen_pkg.sv
// Shared state encoding and 50 MHz default timing for the step/dir pulse generator.
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DSETUP = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } state_t;

  // 1 us pulse, 0.5 us dir setup, 2 us minimum period at 50 MHz
  localparam int DEF_PULSE_WIDTH = 50;
  localparam int DEF_DIR_SETUP   = 25;
  localparam int DEF_MIN_PERIOD  = 100;

endpackage

// File: rtl/step_pulse_gen_timer.sv
// Loadable down-counter; done while the count sits at zero. Loading V gives V+1 cycles to done-edge.
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (cnt != '0)      cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Step/dir pulse generator with guaranteed driver timing and signed position count.
// Optional travel limits enabled by defining STEP_POS_LIMIT_EN.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int WIDTH_WORK  = 16,
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int DIR_SETUP   = DEF_DIR_SETUP,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int POS_WIDTH   = 32
`ifdef STEP_POS_LIMIT_EN
  ,
  parameter int POS_MAX     = 100000,
  parameter int POS_MIN     = -100000
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH_WORK-1:0] N,
  input  logic                  dir_in,
  input  logic                  enable_in,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  busy,
  output logic [POS_WIDTH-1:0]  position
`ifdef STEP_POS_LIMIT_EN
  ,
  output logic                  limit_hit
`endif
);

  localparam logic [WIDTH_WORK-1:0] MIN_P = WIDTH_WORK'(MIN_PERIOD);
  localparam logic [WIDTH_WORK-1:0] PW_M1 = WIDTH_WORK'(PULSE_WIDTH - 1);
  localparam logic [WIDTH_WORK-1:0] PW_P1 = WIDTH_WORK'(PULSE_WIDTH + 1);
  localparam logic [WIDTH_WORK-1:0] DS_W  = WIDTH_WORK'(DIR_SETUP);

  state_t                state_q, state_d;
  logic [WIDTH_WORK-1:0] period_l, period_d, n_clamp, tmr_val;
  logic [POS_WIDTH-1:0]  pos_d;
  logic                  tmr_load, tmr_done, step_d, dir_d, enter_high, blocked;

  step_timer #(.W(WIDTH_WORK)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign n_clamp = (N < MIN_P) ? MIN_P : N;
  assign busy    = (state_q != ST_IDLE);

`ifdef STEP_POS_LIMIT_EN
  localparam logic signed [POS_WIDTH-1:0] P_MAX = POS_WIDTH'(POS_MAX);
  localparam logic signed [POS_WIDTH-1:0] P_MIN = POS_WIDTH'(POS_MIN);
  logic lim_d, lim_dir, lim_dir_d;

  // A step is refused if it would carry position past the limit in its own direction
  assign blocked = drv_dir ? ($signed(position) >= P_MAX) : ($signed(position) <= P_MIN);
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    period_d   = period_l;
    pos_d      = position;
    step_d     = drv_step;
    dir_d      = drv_dir;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    enter_high = 1'b0;
`ifdef STEP_POS_LIMIT_EN
    lim_d      = limit_hit;
    lim_dir_d  = lim_dir;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable_in && (N != '0)) begin
          dir_d    = dir_in;
          period_d = n_clamp;
          tmr_load = 1'b1;
          tmr_val  = DS_W;
          state_d  = ST_DSETUP;
        end
      end
      ST_DSETUP: begin
        if (tmr_done) enter_high = 1'b1;
      end
      ST_HIGH: begin
        if (tmr_done) begin
          step_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = period_l - PW_P1;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (!enable_in) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          if (N == '0) begin
            state_d = ST_IDLE;
          end else if (dir_in != drv_dir) begin
            dir_d    = dir_in;
            period_d = n_clamp;
            tmr_load = 1'b1;
            tmr_val  = DS_W;
            state_d  = ST_DSETUP;
          end else begin
            period_d   = n_clamp;
            enter_high = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_high) begin
      if (blocked) begin
        state_d = ST_IDLE;
`ifdef STEP_POS_LIMIT_EN
        lim_d     = 1'b1;
        lim_dir_d = drv_dir;
`endif
      end else begin
        state_d  = ST_HIGH;
        step_d   = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = PW_M1;
        pos_d    = drv_dir ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
`ifdef STEP_POS_LIMIT_EN
        if (drv_dir != lim_dir) lim_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      period_l <= MIN_P;
      position <= '0;
      drv_step <= 1'b0;
      drv_dir  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_l <= period_d;
      position <= pos_d;
      drv_step <= step_d;
      drv_dir  <= dir_d;
    end
  end

`ifdef STEP_POS_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_hit <= 1'b0;
      lim_dir   <= 1'b0;
    end else begin
      limit_hit <= lim_d;
      lim_dir   <= lim_dir_d;
    end
  end
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: predicts rise times/positions from period arithmetic.
module tb_step_pulse_gen;

  localparam int CP   = 20;
  localparam int HALF = 10;
  localparam int PW   = 50;
  localparam int DS   = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] N;
  logic        dir_in, enable_in;
  logic        drv_step, drv_dir, busy;
  logic [31:0] position;
`ifdef STEP_POS_LIMIT_EN
  logic        limit_hit;
`endif

  int tot = 0;
  int bad = 0;
  logic signed [31:0] exp_pos = 0;

  always #HALF clk = ~clk;

  step_pulse_gen #(
    .WIDTH_WORK(16)
`ifdef STEP_POS_LIMIT_EN
    , .POS_MAX(3), .POS_MIN(-3)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .N         (N),
    .dir_in    (dir_in),
    .enable_in (enable_in),
    .drv_step  (drv_step),
    .drv_dir   (drv_dir),
    .busy      (busy),
    .position  (position)
`ifdef STEP_POS_LIMIT_EN
    , .limit_hit (limit_hit)
`endif
  );

  // Waits (bounded) for drv_step to move to 'want'; t is the clock edge that moved it.
  task automatic wait_edge(input bit want, input int budget, output time t, output bit ok);
    bit p;
    p = drv_step; ok = 1'b0; t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drv_step == want && p != want) begin
        ok = 1'b1; t = $time - HALF; break;
      end
      p = drv_step;
    end
  endtask

  task automatic start(input logic [15:0] n, input bit d, output time s);
    @(negedge clk);
    N = n; dir_in = d; enable_in = 1'b1;
    s = $time + HALF;
  endtask

  // Drop enable while in LOW; report busy one clock later and whether any further pulse appears.
  task automatic halt(output bit busy_after, output bit rose);
    time t;
    @(negedge clk); enable_in = 1'b0;
    @(negedge clk); busy_after = busy;
    wait_edge(1'b1, 300, t, rose);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; N = '0; dir_in = 1'b0; enable_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tot++; if (drv_step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b exp=0", drv_step); end
    tot++; if (drv_dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b exp=0", drv_dir); end
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tot++; if (position !== 32'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", position); end
    exp_pos = 0;
  endtask

  task automatic test_basic;
    time s, tr, tf, exp_r; bit ok, b, r, d; int n;
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 200 : int'($urandom_range(100, 600));
      d = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start(16'(n), d, s);
      exp_r = s + time'((DS + 1) * CP);
      for (int k = 0; k < 3; k++) begin
        wait_edge(1'b1, n + 40, tr, ok);
        tot++; if (!ok || tr != exp_r) begin bad++; $display("FAIL basic_rise it%0d k%0d got=%0d exp=%0d", it, k, tr, exp_r); end
        exp_pos = d ? exp_pos + 1 : exp_pos - 1;
        tot++; if (position !== exp_pos || drv_dir !== d) begin
          bad++; $display("FAIL basic_pos it%0d k%0d got pos=%0d dir=%b exp pos=%0d dir=%b", it, k, $signed(position), drv_dir, exp_pos, d);
        end
        wait_edge(1'b0, PW + 10, tf, ok);
        tot++; if (!ok || tf - tr != time'(PW * CP)) begin bad++; $display("FAIL basic_width it%0d got=%0d exp=%0d", it, tf - tr, PW * CP); end
        exp_r = exp_r + time'(n * CP);
      end
      halt(b, r);
      tot++; if (b !== 1'b0 || r) begin bad++; $display("FAIL basic_halt got busy=%b rose=%b exp busy=0 rose=0", b, r); end
    end
  endtask

  task automatic test_clamp;
    time s, tr, tf, exp_r; bit ok, b, r, d, any_busy, any_step; int n;
    n = int'($urandom_range(1, 99)); d = 1'($urandom_range(0, 1));
    start(16'(n), d, s);
    exp_r = s + time'((DS + 1) * CP);
    for (int k = 0; k < 2; k++) begin
      wait_edge(1'b1, 200, tr, ok);
      tot++; if (!ok || tr != exp_r) begin bad++; $display("FAIL clamp_rise n=%0d k%0d got=%0d exp=%0d", n, k, tr, exp_r); end
      exp_pos = d ? exp_pos + 1 : exp_pos - 1;
      wait_edge(1'b0, PW + 10, tf, ok);
      exp_r = exp_r + time'(100 * CP);
    end
    tot++; if (position !== exp_pos) begin bad++; $display("FAIL clamp_pos got=%0d exp=%0d", $signed(position), exp_pos); end
    halt(b, r);
    tot++; if (b !== 1'b0 || r) begin bad++; $display("FAIL clamp_halt got busy=%b rose=%b exp busy=0 rose=0", b, r); end
    @(negedge clk); N = '0; enable_in = 1'b1;
    any_busy = 1'b0; any_step = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) any_busy = 1'b1;
      if (drv_step) any_step = 1'b1;
    end
    tot++; if (any_busy || any_step) begin bad++; $display("FAIL zero_n got busy=%b step=%b exp busy=0 step=0", any_busy, any_step); end
    enable_in = 1'b0;
  endtask

  task automatic test_dir_change;
    time s, tr, tf, exp_r; bit ok, b, r, d; int n, w;
    n = int'($urandom_range(150, 300)); d = 1'($urandom_range(0, 1));
    start(16'(n), d, s);
    exp_r = s + time'((DS + 1) * CP);
    wait_edge(1'b1, 60, tr, ok);
    tot++; if (!ok || tr != exp_r) begin bad++; $display("FAIL dir_rise0 got=%0d exp=%0d", tr, exp_r); end
    exp_pos = d ? exp_pos + 1 : exp_pos - 1;
    wait_edge(1'b0, PW + 10, tf, ok);
    w = int'($urandom_range(1, n - PW - 10));
    repeat (w) @(negedge clk);
    dir_in = ~d;
    exp_r = exp_r + time'((n + DS + 1) * CP);
    for (int k = 0; k < 2; k++) begin
      wait_edge(1'b1, n + 60, tr, ok);
      tot++; if (!ok || tr != exp_r) begin bad++; $display("FAIL dir_rise k%0d got=%0d exp=%0d", k, tr, exp_r); end
      exp_pos = d ? exp_pos - 1 : exp_pos + 1;
      tot++; if (position !== exp_pos || drv_dir !== ~d) begin
        bad++; $display("FAIL dir_pos k%0d got pos=%0d dir=%b exp pos=%0d dir=%b", k, $signed(position), drv_dir, exp_pos, ~d);
      end
      wait_edge(1'b0, PW + 10, tf, ok);
      exp_r = exp_r + time'(n * CP);
    end
    halt(b, r);
    tot++; if (b !== 1'b0 || r) begin bad++; $display("FAIL dir_halt got busy=%b rose=%b exp busy=0 rose=0", b, r); end
  endtask

  task automatic test_enable_high;
    time s, tr, tf, t; bit ok, d; int n;
    n = int'($urandom_range(100, 400)); d = 1'($urandom_range(0, 1));
    start(16'(n), d, s);
    wait_edge(1'b1, 60, tr, ok);
    exp_pos = d ? exp_pos + 1 : exp_pos - 1;
    repeat ($urandom_range(1, 40)) @(negedge clk);
    enable_in = 1'b0;
    wait_edge(1'b0, PW + 10, tf, ok);
    tot++; if (!ok || tf - tr != time'(PW * CP)) begin bad++; $display("FAIL en_high_width got=%0d exp=%0d", tf - tr, PW * CP); end
    @(negedge clk);
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL en_high_idle got busy=%b exp=0", busy); end
    wait_edge(1'b1, n + 60, t, ok);
    tot++; if (ok || position !== exp_pos) begin bad++; $display("FAIL en_high_extra got rose=%b pos=%0d exp rose=0 pos=%0d", ok, $signed(position), exp_pos); end
  endtask

  task automatic test_period_change;
    time s, tr, tf, exp_r; bit ok, b, r, d;
    d = 1'($urandom_range(0, 1));
    start(16'd200, d, s);
    exp_r = s + time'((DS + 1) * CP);
    wait_edge(1'b1, 60, tr, ok);
    exp_pos = d ? exp_pos + 1 : exp_pos - 1;
    wait_edge(1'b0, PW + 10, tf, ok);
    repeat ($urandom_range(1, 100)) @(negedge clk);
    N = 16'd300;
    exp_r = exp_r + time'(200 * CP);
    wait_edge(1'b1, 260, tr, ok);
    tot++; if (!ok || tr != exp_r) begin bad++; $display("FAIL per_keep got=%0d exp=%0d", tr, exp_r); end
    exp_pos = d ? exp_pos + 1 : exp_pos - 1;
    wait_edge(1'b0, PW + 10, tf, ok);
    exp_r = exp_r + time'(300 * CP);
    wait_edge(1'b1, 360, tr, ok);
    tot++; if (!ok || tr != exp_r) begin bad++; $display("FAIL per_new got=%0d exp=%0d", tr, exp_r); end
    exp_pos = d ? exp_pos + 1 : exp_pos - 1;
    tot++; if (position !== exp_pos) begin bad++; $display("FAIL per_pos got=%0d exp=%0d", $signed(position), exp_pos); end
    wait_edge(1'b0, PW + 10, tf, ok);
    halt(b, r);
  endtask

  task automatic test_reset_mid;
    time s, tr; bit ok, d;
    d = 1'($urandom_range(0, 1));
    start(16'($urandom_range(100, 300)), d, s);
    wait_edge(1'b1, 60, tr, ok);
    repeat ($urandom_range(0, 30)) @(negedge clk);
    tot++; if (drv_step !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got step=%b exp=1", drv_step); end
    #3 rst_n = 1'b0;
    #1;
    tot++; if (drv_step !== 1'b0) begin bad++; $display("FAIL rst_mid_step got=%b exp=0", drv_step); end
    tot++; if (position !== 32'd0) begin bad++; $display("FAIL rst_mid_pos got=%0d exp=0", position); end
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    exp_pos = 0;
    enable_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tot++; if (busy !== 1'b0 || drv_step !== 1'b0) begin bad++; $display("FAIL rst_mid_after got busy=%b step=%b exp 0 0", busy, drv_step); end
  endtask

`ifdef STEP_POS_LIMIT_EN
  task automatic test_limit;
    time s, t; bit ok, p; int cnt;
    start(16'd100, 1'b1, s);
    cnt = 0; p = drv_step;
    repeat (800) begin
      @(negedge clk);
      if (drv_step && !p) cnt++;
      p = drv_step;
    end
    tot++; if (cnt != 3) begin bad++; $display("FAIL limit_count got=%0d exp=3", cnt); end
    tot++; if (limit_hit !== 1'b1) begin bad++; $display("FAIL limit_hit got=%b exp=1", limit_hit); end
    tot++; if (position !== 32'd3) begin bad++; $display("FAIL limit_pos got=%0d exp=3", position); end
    dir_in = 1'b0;
    wait_edge(1'b1, 200, t, ok);
    tot++; if (!ok || position !== 32'd2) begin bad++; $display("FAIL limit_back got ok=%b pos=%0d exp ok=1 pos=2", ok, position); end
    tot++; if (limit_hit !== 1'b0) begin bad++; $display("FAIL limit_clear got=%b exp=0", limit_hit); end
    enable_in = 1'b0;
    exp_pos = 2;
  endtask
`endif

  initial begin
    test_reset();
`ifdef STEP_POS_LIMIT_EN
    test_limit();
`else
    test_basic();
    test_clamp();
    test_dir_change();
    test_enable_high();
    test_period_change();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
